doorlock_ctrl: RTL and testbench

- Consumer side of the keypad press detector.
- Takes one-cycle one-hot keypad pulses (bit i = digit i, 0..9) plus an enter pulse, and assembles a CODE_LEN-digit entry.
- Compares the entry against the stored passcode, drives the door unlock, and enforces a lockout after repeated failures.
- Sits between the keypad edge-detect stage and the lock actuator / status LEDs.

---
 rtl/doorlock_pkg.sv | 27 ++
 rtl/doorlock_timer.sv | 35 +++
 rtl/doorlock_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_doorlock_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doorlock_pkg.sv
// Shared types and helpers for the keypad door lock controller.
// Holds the FSM state encoding and the one-hot key decoder.
package doorlock_pkg;

    localparam int DIGIT_W = 4;
    localparam int KEY_W   = 10;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CHECK   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Returns {valid, digit}. Valid only when exactly one key bit is set.
    function automatic logic [DIGIT_W:0] onehot_to_digit(input logic [KEY_W-1:0] key);
        logic [DIGIT_W:0] res;
        res = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key == (KEY_W'(1) << i)) begin
                res = {1'b1, DIGIT_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
// Shared by the unlock window and the lockout period.
module doorlock_timer #(
    parameter int W = 13
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// Keypad door lock: assembles a CODE_LEN-digit entry, checks it, drives unlock and lockout.
// Define DOORLOCK_CODE_CHANGE_EN to allow rewriting the stored code while the door is open.
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
    parameter int          UNLOCK_CYCLES  = 1000,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 5000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [KEY_W-1:0] button_on,
    input  logic             enter,
    output logic             unlock,
    output logic             error,
    output logic             locked_out,
    output logic [3:0]       digit_cnt,
    output state_t           state_dbg
);

    localparam int BUF_W   = CODE_LEN * DIGIT_W;
    localparam int MAX_DUR = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int FAIL_W  = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

    localparam logic [BUF_W-1:0] RESET_CODE = DEFAULT_CODE[BUF_W-1:0];
    localparam logic [3:0]       CODE_LEN_C = 4'(CODE_LEN);

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic                unlock_q, unlock_d;
    logic                error_q, error_d;
    logic                locked_out_q, locked_out_d;

    logic [BUF_W-1:0]    stored_code;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_val;
    logic                timer_done;

    logic [DIGIT_W:0]    key_dec;
    logic                key_valid;
    logic [DIGIT_W-1:0]  key_digit;
    logic                press_ok;
    logic [BUF_W-1:0]    buf_shift;
    logic                match;
    logic [FAIL_W-1:0]   fail_inc;

    assign key_dec   = onehot_to_digit(button_on);
    assign key_valid = key_dec[DIGIT_W];
    assign key_digit = key_dec[DIGIT_W-1:0];
    // Presses past a full buffer are dropped rather than shifting out old digits.
    assign press_ok  = key_valid && (cnt_q < CODE_LEN_C);
    assign buf_shift = (buf_q << DIGIT_W) | BUF_W'(key_digit);
    assign match     = (cnt_q == CODE_LEN_C) && (buf_q == stored_code);
    assign fail_inc  = fail_q + FAIL_W'(1);

`ifdef DOORLOCK_CODE_CHANGE_EN
    logic [BUF_W-1:0] code_q, code_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code_q <= RESET_CODE;
        end else begin
            code_q <= code_d;
        end
    end

    assign stored_code = code_q;
`else
    assign stored_code = RESET_CODE;
`endif

    doorlock_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        fail_d       = fail_q;
        unlock_d     = unlock_q;
        locked_out_d = locked_out_q;
        error_d      = 1'b0;
        timer_load   = 1'b0;
        timer_val    = '0;
`ifdef DOORLOCK_CODE_CHANGE_EN
        code_d       = code_q;
`endif
        case (state_q)
            ENTRY: begin
                // Enter wins over a simultaneous press; that digit is lost.
                if (enter) begin
                    state_d = CHECK;
                end else if (press_ok) begin
                    buf_d = buf_shift;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (match) begin
                    state_d    = OPEN;
                    fail_d     = '0;
                    unlock_d   = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(UNLOCK_CYCLES - 1);
                end else begin
                    error_d = 1'b1;
                    fail_d  = fail_inc;
                    if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                        state_d      = LOCKOUT;
                        locked_out_d = 1'b1;
                        timer_load   = 1'b1;
                        timer_val    = TIMER_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d = ENTRY;
                    end
                end
            end
            OPEN: begin
                if (timer_done) begin
                    state_d  = ENTRY;
                    unlock_d = 1'b0;
                    buf_d    = '0;
                    cnt_d    = '0;
                end
`ifdef DOORLOCK_CODE_CHANGE_EN
                else if (enter) begin
                    buf_d = '0;
                    cnt_d = '0;
                    if (cnt_q == CODE_LEN_C) begin
                        code_d     = buf_q;
                        state_d    = ENTRY;
                        unlock_d   = 1'b0;
                        timer_load = 1'b1;
                    end
                end else if (press_ok) begin
                    buf_d = buf_shift;
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_d      = ENTRY;
                    fail_d       = '0;
                    locked_out_d = 1'b0;
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ENTRY;
            buf_q        <= '0;
            cnt_q        <= '0;
            fail_q       <= '0;
            unlock_q     <= 1'b0;
            error_q      <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            fail_q       <= fail_d;
            unlock_q     <= unlock_d;
            error_q      <= error_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign unlock     = unlock_q;
    assign error      = error_q;
    assign locked_out = locked_out_q;
    assign digit_cnt  = cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed bench for doorlock_ctrl: stimulus pushes expected output events
// (kind + cycle) into a queue, a negedge monitor pops and compares them.
module tb_doorlock_ctrl;
  import doorlock_pkg::*;

  localparam int UNLOCK_CYCLES  = 1000;
  localparam int LOCKOUT_CYCLES = 5000;

  localparam logic [3:0] EV_ERROR       = 4'd1;
  localparam logic [3:0] EV_LOCK_RISE   = 4'd2;
  localparam logic [3:0] EV_LOCK_FALL   = 4'd3;
  localparam logic [3:0] EV_UNLOCK_RISE = 4'd4;
  localparam logic [3:0] EV_UNLOCK_FALL = 4'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] button_on = '0;
  logic       enter = 1'b0;
  logic       unlock;
  logic       error;
  logic       locked_out;
  logic [3:0] digit_cnt;
  state_t     state_dbg;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic prev_unlock = 1'b0;
  logic prev_lock = 1'b0;

  doorlock_ctrl #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (32'h0000_1234),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .MAX_FAIL       (3),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .button_on  (button_on),
    .enter      (enter),
    .unlock     (unlock),
    .error      (error),
    .locked_out (locked_out),
    .digit_cnt  (digit_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1, "watchdog expired");
  end

  function automatic string ev_name(input logic [3:0] e);
    case (e)
      EV_ERROR:       return "error";
      EV_LOCK_RISE:   return "lock_rise";
      EV_LOCK_FALL:   return "lock_fall";
      EV_UNLOCK_RISE: return "unlock_rise";
      EV_UNLOCK_FALL: return "unlock_fall";
      default:        return "none";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  task automatic push_ev(input logic [3:0] e, input int c);
    exp_q.push_back({e, 28'(c)});
  endtask

  // scoreboard monitor
  task automatic see_ev(input logic [3:0] e);
    logic [31:0] want;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event_unexpected: got %s at cycle %0d, required no event", ev_name(e), cyc);
    end else begin
      want = exp_q.pop_front();
      if (want == {e, 28'(cyc)}) n_pass++;
      else $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                    ev_name(e), cyc, ev_name(want[31:28]), want[27:0]);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      prev_unlock = 1'b0;
      prev_lock   = 1'b0;
    end else begin
      if (error) see_ev(EV_ERROR);
      if (locked_out && !prev_lock) see_ev(EV_LOCK_RISE);
      if (!locked_out && prev_lock) see_ev(EV_LOCK_FALL);
      if (unlock && !prev_unlock) see_ev(EV_UNLOCK_RISE);
      if (!unlock && prev_unlock) see_ev(EV_UNLOCK_FALL);
      prev_unlock = unlock;
      prev_lock   = locked_out;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("reset_unlock", unlock, 0);
    check("reset_error", error, 0);
    check("reset_locked_out", locked_out, 0);
    check("reset_digit_cnt", digit_cnt, 0);
    check("reset_state", state_dbg, ENTRY);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic pulse(input logic [9:0] k, input logic e, output int t);
    @(negedge clock);
    button_on = k;
    enter = e;
    t = cyc;
    @(negedge clock);
    button_on = '0;
    enter = 1'b0;
  endtask

  task automatic key(input int d);
    logic [9:0] k;
    int t;
    k = 10'd1 << d;
    pulse(k, 1'b0, t);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) key(int'(code[i*4 +: 4]));
  endtask

  task automatic submit(output int t);
    pulse('0, 1'b1, t);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // stimulus
  initial begin
    int t;
    logic [15:0] wrong [3];
    wrong[0] = 16'h1235;
    wrong[1] = 16'h0000;
    wrong[2] = 16'h4321;

    do_reset();

    // correct code opens for exactly UNLOCK_CYCLES
    enter_code(16'h1234);
    check("cnt_after_4", digit_cnt, 4);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    push_ev(EV_UNLOCK_FALL, t + 2 + UNLOCK_CYCLES);
    wait_cyc(UNLOCK_CYCLES + 10);
    check("cnt_after_open", digit_cnt, 0);

    // wrong code
    enter_code(16'h1235);
    submit(t);
    push_ev(EV_ERROR, t + 2);
    wait_cyc(4);
    check("cnt_after_error", digit_cnt, 0);
    check("unlock_after_error", unlock, 0);

    // three failures lock out, inputs ignored, then a correct code works
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enter_code(wrong[i]);
      submit(t);
      push_ev(EV_ERROR, t + 2);
      if (i == 2) begin
        push_ev(EV_LOCK_RISE, t + 2);
        push_ev(EV_LOCK_FALL, t + 2 + LOCKOUT_CYCLES);
      end
      wait_cyc(4);
    end
    enter_code(16'h1234);
    check("cnt_in_lockout", digit_cnt, 0);
    submit(t);
    wait_cyc(4);
    check("locked_out_held", locked_out, 1);
    wait_cyc(LOCKOUT_CYCLES);
    enter_code(16'h1234);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    push_ev(EV_UNLOCK_FALL, t + 2 + UNLOCK_CYCLES);
    wait_cyc(UNLOCK_CYCLES + 10);

    // multi-bit press ignored; enter together with 4th digit fails
    do_reset();
    pulse(10'b00_0000_0110, 1'b0, t);
    check("cnt_multibit", digit_cnt, 0);
    pulse(10'b00_0000_0000, 1'b0, t);
    check("cnt_zerobit", digit_cnt, 0);
    enter_code(16'h1234);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    push_ev(EV_UNLOCK_FALL, t + 2 + UNLOCK_CYCLES);
    wait_cyc(UNLOCK_CYCLES + 10);
    key(1);
    key(2);
    key(3);
    pulse(10'd1 << 4, 1'b1, t);
    push_ev(EV_ERROR, t + 2);
    wait_cyc(4);
    check("cnt_after_enter_collide", digit_cnt, 0);

    // fifth digit dropped; empty enter fails
    do_reset();
    enter_code(16'h1234);
    key(9);
    check("cnt_saturates", digit_cnt, 4);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    push_ev(EV_UNLOCK_FALL, t + 2 + UNLOCK_CYCLES);
    wait_cyc(UNLOCK_CYCLES + 10);
    submit(t);
    push_ev(EV_ERROR, t + 2);
    wait_cyc(4);

`ifdef DOORLOCK_CODE_CHANGE_EN
    // rewrite the code while open
    enter_code(16'h1234);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    wait_cyc(4);
    enter_code(16'h5678);
    check("cnt_in_open", digit_cnt, 4);
    submit(t);
    push_ev(EV_UNLOCK_FALL, t + 1);
    wait_cyc(4);
    enter_code(16'h1234);
    submit(t);
    push_ev(EV_ERROR, t + 2);
    wait_cyc(4);
    enter_code(16'h5678);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    wait_cyc(10);
    do_reset();
    enter_code(16'h1234);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    wait_cyc(10);
    do_reset();
`else
    // inputs ignored while open, then reset mid-open relocks
    enter_code(16'h1234);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    push_ev(EV_UNLOCK_FALL, t + 2 + UNLOCK_CYCLES);
    wait_cyc(4);
    enter_code(16'h5678);
    check("cnt_in_open", digit_cnt, 0);
    submit(t);
    wait_cyc(4);
    check("unlock_still_open", unlock, 1);
    wait_cyc(UNLOCK_CYCLES);
    enter_code(16'h1234);
    submit(t);
    push_ev(EV_UNLOCK_RISE, t + 2);
    wait_cyc(10);
    do_reset();
`endif

    wait_cyc(5);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    while (exp_q.size() > 0) begin
      logic [31:0] left;
      left = exp_q.pop_front();
      $display("FAIL event_missing: got nothing, required %s at cycle %0d",
               ev_name(left[31:28]), left[27:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
